// File: rtl/cic3_pkg.sv
// ---------------------------------------------------------------------------
// cic3_pkg
// Shared constants and helpers for the third-order CIC decimator.
//   R_DEFAULT    : default decimation ratio (power of two, >= 2)
//   N            : filter order, fixed at 3
//   W_DEFAULT    : default datapath/output width, N*log2(R_DEFAULT)+1
//   cic_word_t   : datapath word at the default width
//   cic_out_width: lossless output width for a given R and N
// ---------------------------------------------------------------------------
package cic3_pkg;

    localparam int R_DEFAULT = 256;
    localparam int N         = 3;
    localparam int W_DEFAULT = 25;

    typedef logic [W_DEFAULT-1:0] cic_word_t;

    // The DC gain is R^N, so a 0/1 input needs N*log2(R) bits plus one
    // to represent the full-scale value R^N itself.
    function automatic int cic_out_width(input int r, input int n);
        return n * $clog2(r) + 1;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// ---------------------------------------------------------------------------
// cic_comb_stage
// One CIC differentiator (differential delay 1) running at the decimated
// rate: y = x - x_prev, where x_prev is captured only when en_i is high.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous reset, active high (clears the delay register)
//   en_i     : decimation strobe; advances the delay register
//   x_i      : input word (W bits)
//   y_o      : differentiated output word (W bits, combinational)
// ---------------------------------------------------------------------------
module cic_comb_stage #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    logic [W-1:0] dly_q;
    logic [W-1:0] dly_d;

    // Modular subtract: integrator wrap-around cancels here exactly.
    assign y_o = x_i - dly_q;

    always_comb begin
        dly_d = dly_q;
        if (en_i) begin
            dly_d = x_i;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

endmodule

// File: rtl/cic3_decim.sv
// ---------------------------------------------------------------------------
// cic3_decim
// Third-order CIC decimator for a 1-bit sigma-delta bitstream. Three
// integrators run at the clock rate, a log2(R)-bit counter produces a strobe
// every R clocks, and three comb stages evaluated on that strobe produce an
// unsigned W-bit sample that is registered and held until the next strobe.
// Ports:
//   clk      : clock; the modulator bit rate equals the clock rate
//   reset_n  : asynchronous reset, active high (name kept from the system
//              netlist); clears integrators, combs, counter and output
//   in       : modulator bit, unsigned 0/1
//   out      : decimated sample, unsigned, full scale R^3
// ---------------------------------------------------------------------------
module cic3_decim
    import cic3_pkg::*;
#(
    parameter int R = R_DEFAULT,
    parameter int W = cic_out_width(R_DEFAULT, N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in,
    output logic [W-1:0] out
);

    localparam int CW = $clog2(R);

    // ---------------- integrators (clock rate, modular) -------------------
    logic [W-1:0] integ_q   [N];
    logic [W-1:0] integ_d   [N];
    logic [W-1:0] integ_src [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_integ
            if (gi == 0) begin : g_first
                assign integ_src[gi] = {{(W-1){1'b0}}, in};
            end else begin : g_chain
                assign integ_src[gi] = integ_q[gi-1];
            end
            // Wrap-around is intended; no saturation.
            assign integ_d[gi] = integ_q[gi] + integ_src[gi];

            always_ff @(posedge clk or posedge reset_n) begin
                if (reset_n) begin
                    integ_q[gi] <= '0;
                end else begin
                    integ_q[gi] <= integ_d[gi];
                end
            end
        end
    endgenerate

    // ---------------- decimation counter ----------------------------------
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          strobe;

    // R is a power of two, so natural overflow gives the R-1 -> 0 wrap.
    assign cnt_d  = cnt_q + 1'b1;
    assign strobe = (cnt_q == CW'(R - 1));

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ---------------- combs (decimated rate) ------------------------------
    // comb_c[0] is the last integrator; comb_c[N] is the filter result.
    logic [W-1:0] comb_c [N+1];

    assign comb_c[0] = integ_q[N-1];

    generate
        for (gi = 0; gi < N; gi++) begin : g_comb
            cic_comb_stage #(
                .W (W)
            ) u_comb (
                .clk     (clk),
                .reset_n (reset_n),
                .en_i    (strobe),
                .x_i     (comb_c[gi]),
                .y_o     (comb_c[gi+1])
            );
        end
    endgenerate

    // ---------------- output register -------------------------------------
    logic [W-1:0] out_q;
    logic [W-1:0] out_d;

    always_comb begin
        out_d = out_q;
        if (strobe) begin
            out_d = comb_c[N];
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_cic3_decim.sv
// ---------------------------------------------------------------------------
// tb_cic3_decim
// Scoreboard bench for cic3_decim. The stimulus process pushes the expected
// value of every strobe of a run (exact values for settled outputs, bounds
// for transients) and a monitor process pops and compares one entry each
// time R clocks have elapsed since reset release. Includes behavioural
// sine_wave / sdm_rnm models as a real-valued bitstream source.
// ---------------------------------------------------------------------------
module tb_cic3_decim;

    localparam int R = 256;
    localparam int W = 25;

    localparam logic [W-1:0] FULL  = 25'd16777216;
    localparam logic [W-1:0] HALF  = 25'd8388608;
    localparam logic [W-1:0] QUART = 25'd4194304;

    // Hand-computed step response of a fresh run with in = 1 from the first
    // edge: third differences of C(nR-1,3) for n = 1..3.
    localparam logic [W-1:0] STEP1 = 25'd2731135;
    localparam logic [W-1:0] STEP2 = 25'd13915010;
    localparam logic [W-1:0] STEP3 = 25'd16777215;

    localparam int TAG_ONES  = 0;
    localparam int TAG_ZEROS = 1;
    localparam int TAG_ALT   = 2;
    localparam int TAG_QTR   = 3;
    localparam int TAG_ASYNC = 4;
    localparam int TAG_FRESH = 5;
    localparam int TAG_SINE  = 6;

    localparam int KIND_EXACT = 0;
    localparam int KIND_RANGE = 1;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b1;
    logic         in      = 1'b0;
    logic [W-1:0] out;

    always #5 clk = ~clk;

    cic3_decim #(
        .R (R),
        .W (W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (in),
        .out     (out)
    );

    typedef struct {
        int           kind;
        int           tag;
        int           idx;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } exp_t;

    exp_t exp_q[$];

    int  n_checks = 0;
    int  n_errors = 0;

    // ---------------- helpers ---------------------------------------------
    function automatic string tag_name(input int t);
        case (t)
            TAG_ONES:  return "ones";
            TAG_ZEROS: return "zeros";
            TAG_ALT:   return "alt10";
            TAG_QTR:   return "pat1000";
            TAG_ASYNC: return "pre_async";
            TAG_FRESH: return "fresh_after_async";
            TAG_SINE:  return "sine";
            default:   return "unknown";
        endcase
    endfunction

    real sdm_integ = 0.0;

    function automatic real sine_wave(input int c);
        return 0.5 + 0.4 * $sin(2.0 * 3.14159265358979 * real'(c) / 8192.0);
    endfunction

    // First-order sigma-delta modulator, real-valued.
    function automatic logic sdm_rnm(input real x);
        logic y;
        y = (sdm_integ >= 0.0) ? 1'b1 : 1'b0;
        sdm_integ = sdm_integ + x - (y ? 1.0 : 0.0);
        return y;
    endfunction

    // ---------------- strobe tracker and monitor --------------------------
    int   edge_cnt;
    exp_t mon_e;
    logic mon_ok;
    real  sine_sum = 0.0;
    int   sine_n   = 0;

    always @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            edge_cnt <= 0;
        end else begin
            edge_cnt <= edge_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset_n && edge_cnt == R - 1) begin
            n_checks++;
            if (out !== '0) begin
                n_errors++;
                $display("FAIL hold_before_first_strobe: out=%0d required 0", out);
            end
        end
        if (!reset_n && edge_cnt > 0 && (edge_cnt % R) == 0 && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (mon_e.kind == KIND_EXACT) begin
                mon_ok = (out === mon_e.lo);
            end else begin
                mon_ok = !$isunknown(out) && (out >= mon_e.lo) && (out <= mon_e.hi);
            end
            if (!mon_ok) begin
                n_errors++;
                if (mon_e.kind == KIND_EXACT) begin
                    $display("FAIL %s[%0d]: out=%0d required %0d",
                             tag_name(mon_e.tag), mon_e.idx, out, mon_e.lo);
                end else begin
                    $display("FAIL %s[%0d]: out=%0d required %0d..%0d",
                             tag_name(mon_e.tag), mon_e.idx, out, mon_e.lo, mon_e.hi);
                end
            end else begin
                $display("strobe %s[%0d]: out=%0d ok", tag_name(mon_e.tag), mon_e.idx, out);
            end
            if (mon_e.tag == TAG_SINE && mon_e.idx >= 5) begin
                sine_sum = sine_sum + real'(out);
                sine_n++;
            end
        end
    end

    // ---------------- stimulus tasks --------------------------------------
    task automatic push_exp(input int kind, input int tag, input int idx,
                            input logic [W-1:0] lo, input logic [W-1:0] hi);
        exp_t e;
        e.kind = kind;
        e.tag  = tag;
        e.idx  = idx;
        e.lo   = lo;
        e.hi   = hi;
        exp_q.push_back(e);
    endtask

    // Hold reset for a few clocks and check the output is cleared.
    task automatic start_run(input int tag);
        @(negedge clk);
        reset_n = 1'b1;
        in      = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out !== '0) begin
            n_errors++;
            $display("FAIL reset_out(%s): out=%0d required 0", tag_name(tag), out);
        end else begin
            $display("reset %s: out=0 ok", tag_name(tag));
        end
    endtask

    // Release reset (at a falling edge) and drive a periodic pattern.
    task automatic drive_pattern(input logic [3:0] pat, input int plen, input int ncycles);
        for (int c = 0; c < ncycles; c++) begin
            in      = pat[c % plen];
            reset_n = 1'b0;
            @(negedge clk);
        end
    endtask

    // Bounded wait for the monitor to consume every pushed expectation.
    task automatic wait_drain(input int tag);
        for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain(%s): pending=%0d required 0", tag_name(tag), exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic push_step(input int tag, input int nfull);
        push_exp(KIND_EXACT, tag, 1, STEP1, STEP1);
        push_exp(KIND_EXACT, tag, 2, STEP2, STEP2);
        push_exp(KIND_EXACT, tag, 3, STEP3, STEP3);
        for (int k = 0; k < nfull; k++) begin
            push_exp(KIND_EXACT, tag, 4 + k, FULL, FULL);
        end
    endtask

    task automatic push_periodic(input int tag, input logic [W-1:0] final_v, input int nstrobes);
        for (int k = 1; k <= nstrobes; k++) begin
            if (k <= 3) begin
                push_exp(KIND_RANGE, tag, k, '0, final_v);
            end else begin
                push_exp(KIND_EXACT, tag, k, final_v, final_v);
            end
        end
    endtask

    // ---------------- main sequence ---------------------------------------
    initial begin
        real mean;

        // Constant ones: exact step response, then full scale for 100 strobes
        // (the integrators wrap many times over this run).
        start_run(TAG_ONES);
        push_step(TAG_ONES, 100);
        drive_pattern(4'b1111, 1, 103 * R);
        wait_drain(TAG_ONES);

        // Constant zeros.
        start_run(TAG_ZEROS);
        for (int k = 1; k <= 8; k++) push_exp(KIND_EXACT, TAG_ZEROS, k, '0, '0);
        drive_pattern(4'b0000, 1, 8 * R);
        wait_drain(TAG_ZEROS);

        // 1,0,1,0,... -> half scale.
        start_run(TAG_ALT);
        push_periodic(TAG_ALT, HALF, 10);
        drive_pattern(4'b0001, 2, 10 * R);
        wait_drain(TAG_ALT);

        // 1,0,0,0,... -> quarter scale.
        start_run(TAG_QTR);
        push_periodic(TAG_QTR, QUART, 10);
        drive_pattern(4'b0001, 4, 10 * R);
        wait_drain(TAG_QTR);

        // Mid-period asynchronous reset, then a fresh run must match exactly.
        start_run(TAG_ASYNC);
        push_step(TAG_ASYNC, 3);
        drive_pattern(4'b1111, 1, 6 * R + R / 2);
        wait_drain(TAG_ASYNC);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (out !== '0) begin
            n_errors++;
            $display("FAIL async_clear: out=%0d required 0", out);
        end else begin
            $display("async reset: out=0 ok");
        end
        start_run(TAG_FRESH);
        push_step(TAG_FRESH, 5);
        drive_pattern(4'b1111, 1, 8 * R);
        wait_drain(TAG_FRESH);

        // Sigma-delta bitstream of a sine; outputs bounded, mean at mid-scale.
        start_run(TAG_SINE);
        for (int k = 1; k <= 36; k++) push_exp(KIND_RANGE, TAG_SINE, k, '0, FULL);
        sdm_integ = 0.0;
        for (int c = 0; c < 36 * R; c++) begin
            in      = sdm_rnm(sine_wave(c));
            reset_n = 1'b0;
            @(negedge clk);
        end
        wait_drain(TAG_SINE);
        n_checks++;
        mean = (sine_n > 0) ? sine_sum / real'(sine_n) : 0.0;
        if (sine_n != 32 || mean < 8126464.0 || mean > 8650752.0) begin
            n_errors++;
            $display("FAIL sine_mean: mean=%0f over %0d strobes required 8388608 +/- 262144 over 32",
                     mean, sine_n);
        end else begin
            $display("sine mean: %0f over %0d strobes ok", mean, sine_n);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cic3_decim.md
# cic3_decim

Third-order cascaded integrator-comb (CIC) decimation filter for a 1-bit sigma-delta modulator bitstream. It integrates the modulator output at the full clock rate, decimates by R, differentiates at the decimated rate, and presents a 25-bit unsigned result. It sits directly behind the modulator model (sdm_rnm, driven by the sine_wave stimulus source) and is the first digital stage of the ADC signal path.

## Interface
- R, 256: decimation ratio. Must be a power of two and at least 2.
- N, 3: filter order. Fixed at 3 and not overridable.
- W, 25: datapath and output width. Must equal N*log2(R)+1.
- clk  in  1  single clock. All state is updated on its rising edge; the modulator bit rate equals the clk rate.
- reset_n  in  1  asynchronous, active-high reset. Asserted when 1. Clears all state immediately.
- in  in  1  modulator bit, read as unsigned 0 or 1.
- out  out  W  filtered, decimated sample. Unsigned. Updates once every R clocks and holds between updates.

## Operation
- Integrators (3, registered, clk rate):
  - i1 <= i1 + in
  - i2 <= i2 + i1
  - i3 <= i3 + i2
  - Each is W bits, modular (two's-complement wrap, no saturation). Wrap is intentional; the combs cancel it exactly.
- Decimation counter:
  - log2(R) bits, increments every clk, wraps R-1 -> 0.
  - strobe = (count == R-1).
- Combs (3, differential delay M=1, evaluated only on strobe):
  - c0 = i3
  - ck = c(k-1) - dk for k = 1..3
  - dk <= c(k-1) on strobe
  - All subtractions are W-bit modular.
- Output: out <= c3 on strobe; otherwise out holds its value.
- DC gain is R^3 = 2^24.
  - All-ones input settles to 2^24 = 16777216 (25'h1000000).
  - All-zeros input gives 0.
  - A duty cycle of p gives p*2^24 exactly in steady state.
- The output never exceeds 2^24 for a valid 0/1 input, so 25 bits is lossless.

## Timing
- While reset_n = 1, all of the following are 0:
  - integrators and comb delays
  - counter
  - out
- The first strobe occurs at the R-th rising edge after reset release.
- Latency and settling:
  - A step in input is fully reflected in out within 4 strobes (N+1), i.e. within 4R clocks.
  - After that, out is exactly the final value.
  - Intermediate outputs follow the CIC step response: monotonic and bounded by the final value.
- Asserting reset mid-operation clears everything asynchronously. Operation restarts exactly as after power-up, with no residue from the previous run.
- There is no valid or handshake signal. Consumers sample out in the cycle after a strobe, or at any time, since out is stable for R-1 clocks.

## Structure
- Package cic3_pkg contains:
  - localparams R_DEFAULT=256, N=3, W_DEFAULT=25
  - typedef logic [W-1:0] cic_word_t
  - a function computing the output width from R and N
- Sub-module cic_comb_stage: a single differentiator with W-bit modular subtract, a delay register, an enable (strobe) and async reset. It is instantiated three times.
- Integrators and the counter stay inline in cic3_decim.
- sine_wave and sdm_rnm are behavioural, real-valued bench models only. They are not part of the synthesizable block.

## Test plan
- Reset held, then in=1 constantly after release -> out=0 during reset; out reaches exactly 16777216 by the 4th strobe and stays there for 100 strobes.
- in=0 constantly -> out=0 at every strobe.
- Alternating pattern 1,0,1,0,... -> steady out=8388608. Pattern 1,0,0,0 -> out=4194304.
- Constant in=1 for 200000 clocks (integrators wrap many times) -> out remains exactly 16777216 at every strobe after settling.
- Assert reset_n=1 asynchronously in the middle of a decimation period -> out and all state go to 0 without waiting for a clock edge. After release, the first strobe comes R clocks later, and the output matches a fresh run.
- Drive from sdm_rnm fed by sine_wave -> out tracks the sine, staying within 0..16777216, centred near 8388608.
